// File: rtl/logic_net_driver.sv
// logic_net_driver: LFSR stimulus driver and self-checker for the logic_net netlist
// (OUT = NAND(FF(IN1), IN2), registered). Optional first-failure capture: LOGIC_NET_DRV_FIRST_FAIL_EN.
module logic_net_driver #(
  parameter int unsigned       LFSR_W      = 16,
  parameter logic [LFSR_W-1:0] SEED        = 16'hACE1,
  parameter int unsigned       NUM_VECTORS = 256,
  parameter int unsigned       ERR_CNT_W   = 8
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 start,
  output logic                 IN1_o,
  output logic                 IN2_o,
  input  logic                 OUT_i,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_count
`ifdef LOGIC_NET_DRV_FIRST_FAIL_EN
  ,output logic                 fail_valid
  ,output logic [$clog2(NUM_VECTORS)-1:0] fail_idx
`endif
);

  localparam int unsigned          CNT_W    = $clog2(NUM_VECTORS);
  localparam logic [CNT_W-1:0]     LAST_VEC = CNT_W'(NUM_VECTORS - 1);
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
  localparam logic [ERR_CNT_W-1:0] ERR_ONE  = ERR_CNT_W'(1);
  localparam logic [LFSR_W-1:0]    POLY     = LFSR_W'(16'hB400);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            r_state;
  logic [LFSR_W-1:0] r_lfsr;
  logic [CNT_W-1:0]  r_vec_cnt;
  logic [CNT_W-1:0]  r_chk_idx;
  logic [1:0]        r_drain_cnt;
  logic              r_in1_d1;
  logic              r_in1_d2;
  logic              r_in2_d1;
  logic [2:0]        r_chk_pipe;

  logic [LFSR_W-1:0] w_lfsr_next;
  logic              w_expect;
  logic              w_mismatch;
  logic              w_chk_en;
  logic              w_chk_new;

  assign w_lfsr_next = r_lfsr[0] ? ((r_lfsr >> 1) ^ POLY) : (r_lfsr >> 1);
  // Sample at end of cycle k+2 checks IN1[k] (two cycles back) against IN2[k+1] (one back).
  assign w_expect    = ~(r_in1_d2 & r_in2_d1);
  assign w_chk_new   = (r_state == S_RUN) && (r_vec_cnt != LAST_VEC);
  assign w_chk_en    = r_chk_pipe[2];

`ifdef SYNTHESIS
  assign w_mismatch = (OUT_i != w_expect);
`else
  // X/Z on OUT_i counts as a mismatch in simulation.
  assign w_mismatch = (OUT_i !== w_expect);
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state     <= S_IDLE;
      r_lfsr      <= SEED;
      r_vec_cnt   <= '0;
      r_chk_idx   <= '0;
      r_drain_cnt <= '0;
      r_in1_d1    <= 1'b0;
      r_in1_d2    <= 1'b0;
      r_in2_d1    <= 1'b0;
      r_chk_pipe  <= '0;
      IN1_o       <= 1'b0;
      IN2_o       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      err_count   <= '0;
`ifdef LOGIC_NET_DRV_FIRST_FAIL_EN
      fail_valid  <= 1'b0;
      fail_idx    <= '0;
`endif
    end else begin
      r_in1_d1   <= IN1_o;
      r_in1_d2   <= r_in1_d1;
      r_in2_d1   <= IN2_o;
      r_chk_pipe <= {r_chk_pipe[1:0], w_chk_new};

      if (w_chk_en) begin
        r_chk_idx <= r_chk_idx + CNT_ONE;
        if (w_mismatch) begin
          if (err_count != '1) begin
            err_count <= err_count + ERR_ONE;
          end
`ifdef LOGIC_NET_DRV_FIRST_FAIL_EN
          if (!fail_valid) begin
            fail_valid <= 1'b1;
            fail_idx   <= r_chk_idx;
          end
`endif
        end
      end

      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state     <= S_RUN;
            r_lfsr      <= SEED;
            r_vec_cnt   <= '0;
            r_chk_idx   <= '0;
            r_drain_cnt <= '0;
            r_in1_d1    <= 1'b0;
            r_in1_d2    <= 1'b0;
            r_in2_d1    <= 1'b0;
            r_chk_pipe  <= '0;
            done        <= 1'b0;
            pass        <= 1'b0;
            err_count   <= '0;
`ifdef LOGIC_NET_DRV_FIRST_FAIL_EN
            fail_valid  <= 1'b0;
            fail_idx    <= '0;
`endif
          end
        end
        S_RUN: begin
          IN1_o  <= r_lfsr[0];
          IN2_o  <= r_lfsr[1];
          busy   <= 1'b1;
          r_lfsr <= w_lfsr_next;
          if (r_vec_cnt == LAST_VEC) begin
            r_state     <= S_DRAIN;
            r_drain_cnt <= '0;
          end else begin
            r_vec_cnt <= r_vec_cnt + CNT_ONE;
          end
        end
        S_DRAIN: begin
          // Pins lag the state by one edge, so the third DRAIN edge closes the run.
          IN1_o <= 1'b0;
          IN2_o <= 1'b0;
          if (r_drain_cnt == 2'd2) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= (err_count == '0);
            r_state <= S_DONE;
          end else begin
            r_drain_cnt <= r_drain_cnt + 2'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
